// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable data memory with load/store unit.
// One request per cycle, 1-cycle response, optional zero-fill at reset.
module dmem_lsu #(
  parameter int DWIDTH         = 64,
  parameter int DEPTH          = 4096,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [$clog2(DEPTH)+$clog2(DWIDTH/8)-1:0] req_addr,
  input  logic [DWIDTH-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DWIDTH-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                init_busy
);

  localparam int NBYTE  = DWIDTH / 8;
  localparam int OFS    = $clog2(NBYTE);
  localparam int WAW    = $clog2(DEPTH);
  localparam int AWIDTH = WAW + OFS;

  typedef enum logic {INIT, RUN} state_t;
  localparam state_t RST_ST = CLEAR_ON_RESET ? INIT : RUN;

  state_t state, state_n;
  logic [WAW-1:0] cnt;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rd_q;

  logic [OFS-1:0]    lane, lane_q;
  logic [2:0]        lane3;
  logic [1:0]        size_q;
  logic              uns_q, ld_q;
  logic              clr, acc, mis, ill, err, wr;
  logic [3:0]        nb;
  logic [7:0]        bmask, be_full;
  logic [NBYTE-1:0]  be;
  logic [WAW-1:0]    idx, maddr;
  logic [DWIDTH-1:0] wd, wd_st;
  logic [DWIDTH-1:0] sh, keep, ext;
  logic              sb;

  assign lane  = req_addr[OFS-1:0];
  assign lane3 = 3'(lane);
  assign idx   = req_addr[AWIDTH-1:OFS];

  assign clr       = !rst && (state == INIT);
  assign req_ready = !rst && (state == RUN) && (!resp_valid || resp_ready);
  assign init_busy = rst ? CLEAR_ON_RESET : (state == INIT);
  assign acc       = req_valid && req_ready;

  // State register and clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_ST;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  // Leave INIT once the last word has been cleared
  always_comb begin
    state_n = state;
    if (state == INIT && cnt == WAW'(DEPTH - 1)) state_n = RUN;
  end

  // Alignment check: low address bits must be zero for the access size
  always_comb begin
    mis = 1'b0;
    unique case (req_size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = lane3[0];
      2'd2:    mis = |lane3[1:0];
      default: mis = |lane3;
    endcase
  end

  assign ill = (DWIDTH == 32) && (req_size == 2'd3);
  assign err = mis || ill;

  assign nb      = 4'd1 << req_size;
  assign bmask   = 8'((16'd1 << nb) - 16'd1);
  assign be_full = bmask << lane;
  assign wd_st   = req_wdata << {lane, 3'b000};

  assign wr    = clr || (acc && req_we && !err);
  assign maddr = clr ? cnt : idx;
  assign be    = clr ? '1 : be_full[NBYTE-1:0];
  assign wd    = clr ? '0 : wd_st;

  // Single-port byte-enabled RAM, read-first registered read
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (be[b]) mem[maddr][b*8 +: 8] <= wd[b*8 +: 8];
      end
    end
    if (acc) rd_q <= mem[maddr];
  end

  // Response registers, held until the consumer takes them
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      ld_q       <= 1'b0;
      lane_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
    end else if (acc) begin
      resp_valid <= 1'b1;
      resp_err   <= err;
      ld_q       <= !req_we && !err;
      lane_q     <= lane;
      size_q     <= req_size;
      uns_q      <= req_unsigned;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign sh = rd_q >> {lane_q, 3'b000};

  // Load extraction: keep low bytes, then sign- or zero-extend
  always_comb begin
    keep = '1;
    sb   = 1'b0;
    unique case (size_q)
      2'd0: begin
        keep = DWIDTH'(64'hFF);
        sb   = sh[7];
      end
      2'd1: begin
        keep = DWIDTH'(64'hFFFF);
        sb   = sh[15];
      end
      2'd2: begin
        keep = DWIDTH'(64'hFFFF_FFFF);
        sb   = sh[31];
      end
      default: begin
        keep = '1;
        sb   = 1'b0;
      end
    endcase
  end

  assign ext = (sh & keep) | ((sb && !uns_q) ? ~keep : '0);
  assign resp_rdata = ld_q ? ext : '0;

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 64, meaning data width in bits (64 or 32 only).
REQ-002 The block SHALL have parameter DEPTH, default 4096, meaning the number of DWIDTH-bit words (power of two).
REQ-003 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning memory is zero-filled after reset when 1.
REQ-004 The block SHALL derive localparams NBYTE=DWIDTH/8, OFS=log2(NBYTE), WAW=log2(DEPTH) and AWIDTH=WAW+OFS.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Ports SHALL be:
- clk: input, 1, global clock.
- rst: input, 1, synchronous active-high reset.
- req_valid: input, 1, request present.
- req_ready: output, 1, request accepted when high together with req_valid.
- req_we: input, 1, 1 = store, 0 = load.
- req_size: input, 2, access size: 00 byte, 01 half, 10 word, 11 double.
- req_unsigned: input, 1, zero-extend a load when 1.
- req_addr: input, AWIDTH, byte address.
- req_wdata: input, DWIDTH, store data, LSB-justified.
- resp_valid: output, 1, response present.
- resp_ready: input, 1, response consumed when high together with resp_valid.
- resp_rdata: output, DWIDTH, load result.
- resp_err: output, 1, misaligned or illegal request.
- init_busy: output, 1, clear in progress.

Function
REQ-007 The FSM SHALL have two states: INIT (clearing) and RUN.
REQ-008 INIT SHALL write zero to word index cnt, with cnt counting 0..DEPTH-1 one word per cycle, then enter RUN; init_busy SHALL be 1 and req_ready SHALL be 0 throughout INIT.
REQ-009 With CLEAR_ON_RESET=0, reset SHALL enter RUN directly.
REQ-010 In RUN, req_ready SHALL equal !resp_valid || resp_ready, giving one request per cycle without backpressure.
REQ-011 A request SHALL be accepted on a clock edge where req_valid && req_ready.
REQ-012 The response for that request SHALL appear on the next edge: resp_valid=1, i.e. 1-cycle latency.
REQ-013 The response registers SHALL hold resp_valid, resp_rdata and resp_err stable until resp_valid && resp_ready.
REQ-014 resp_valid SHALL clear after a handshake unless a new request is accepted on the same edge.
REQ-015 A request is misaligned when req_addr mod 2^req_size != 0; it SHALL be flagged resp_err=1.
REQ-016 When DWIDTH=32, req_size=11 SHALL be flagged resp_err=1.
REQ-017 An errored request SHALL perform no memory write and SHALL return resp_rdata=0.
REQ-018 Word index SHALL be req_addr[AWIDTH-1:OFS] and byte lane SHALL be req_addr[OFS-1:0].
REQ-019 A store SHALL assert byte enables only for lanes lane..lane+2^size-1.
REQ-020 A store SHALL place req_wdata[8*2^size-1:0] shifted left by 8*lane into the word, leaving other bytes unchanged.
REQ-021 A store response SHALL have resp_rdata=0 and resp_err as applicable.
REQ-022 A load SHALL shift the read word right by 8*lane.
REQ-023 A load SHALL take the low 8*2^size bits, then sign-extend to DWIDTH, or zero-extend if req_unsigned.
REQ-024 req_unsigned with size 11 SHALL be ignored.
REQ-025 The RAM SHALL be a single-port array with per-byte write enables and registered read, inferable as block RAM.
REQ-026 The RAM SHALL operate read-first.
REQ-027 Lane and size SHALL be registered alongside the read so extension is applied in the response cycle.
REQ-028 A load accepted the cycle after a store to the same word SHALL return the stored data.
REQ-029 A load and store never coincide on one edge, since the block is single-request.

Reset
REQ-030 While rst=1: resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0, cnt=0, and the state SHALL be INIT if CLEAR_ON_RESET else RUN.
REQ-031 init_busy SHALL be 1 during reset when CLEAR_ON_RESET=1, else 0.
REQ-032 Reset mid-INIT SHALL restart the clear from cnt=0.
REQ-033 Reset with a pending response SHALL drop the response, and any accepted store SHALL already have completed.
REQ-034 Memory contents SHALL NOT be reset when CLEAR_ON_RESET=0.

Verification
REQ-035 Clear (DEPTH=16): release rst -> init_busy high exactly 16 cycles, then req_ready=1; loading any address returns 0.
REQ-036 Byte/half store-load (DWIDTH=64): store D 0x1122334455667788 @0x08, store B 0x80 @0x0B, load B @0x0B -> 0xFFFFFFFFFFFFFF80; LBU -> 0x80; load H @0x0A -> 0xFFFFFFFFFFFF8066; load D @0x08 -> 0x1122334480667788.
REQ-037 Misaligned: load W @0x06 -> resp_err=1, rdata=0; store H @0x03 -> resp_err=1, and a subsequent load D shows the word unchanged.
REQ-038 Backpressure: resp_ready=0 for 3 cycles with req_valid held -> req_ready=0 and the response is stable; on resp_ready=1, the next request is accepted on the same edge and streaming resumes at 1 per cycle.
REQ-039 Back-to-back: store W 0xDEADBEEF @0x10, then load WU @0x10 next cycle -> 0x00000000DEADBEEF.
REQ-040 Reset at cnt=5 during INIT -> the clear restarts, with init_busy high DEPTH further cycles.
